// File: rtl/route_lookup_ctrl.sv
// route_lookup_ctrl: sequences lookups and route updates onto the TCAM's single
// addr_in/wr_en port, one operation in flight, and returns lookup results in
// order through a small result FIFO with valid/ready backpressure.
// Optional counters: define LOOKUP_STATS_EN to add stat_lookups / stat_updates.
module route_lookup_ctrl #(
    parameter int TAG_W      = 8,
    parameter int RES_DEPTH  = 4,
    parameter int LOOKUP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [31:0]      lk_dst,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_next_hop,
    output logic [3:0]       res_if_idx,
    output logic [31:0]      res_prefix,
    output logic [TAG_W-1:0] res_tag,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [7:0]       upd_index,
    input  logic [3:0]       upd_if_idx,
    input  logic [31:0]      upd_mask,
    input  logic [31:0]      upd_prefix,
    output logic [67:0]      tcam_addr,
    output logic             tcam_wr_en,
    output logic [7:0]       tcam_wr_index,
    input  logic [31:0]      tcam_addr_out,
    input  logic [3:0]       tcam_if_idx,
    input  logic [31:0]      tcam_prefix_size,
    output logic             busy
`ifdef LOOKUP_STATS_EN
    ,
    output logic [31:0]      stat_lookups,
    output logic [31:0]      stat_updates
`endif
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(LOOKUP_LAT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    typedef struct packed {
        logic [31:0]      next_hop;
        logic [3:0]       if_idx;
        logic [31:0]      prefix;
        logic [TAG_W-1:0] tag;
    } res_t;

    state_t           state_q;
    logic [67:0]      tcam_addr_q;
    logic             tcam_wr_en_q;
    logic [7:0]       tcam_wr_index_q;
    logic [TAG_W-1:0] tag_q;
    logic [LAT_W-1:0] wait_cnt_q;
    logic             upd_prio_q;     // 1: next contended accept goes to the update side

    res_t             mem_q [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fifo_full, push, pop, lk_fire, upd_fire;
    res_t head;

    // Space is reserved at issue time, so a lookup is only accepted when the
    // FIFO can take its result. Both readies are held off while in reset.
    assign fifo_full = (cnt_q == CNT_W'(RES_DEPTH));
    assign lk_ready  = rst_n && (state_q == IDLE) && !fifo_full &&
                       (!upd_valid || !upd_prio_q);
    assign upd_ready = rst_n && (state_q == IDLE) && upd_valid &&
                       (!lk_valid || upd_prio_q || fifo_full);
    assign lk_fire   = lk_valid && lk_ready;
    assign upd_fire  = upd_valid && upd_ready;

    assign push = (state_q == WAIT) && (wait_cnt_q == LAT_W'(1));
    assign pop  = res_valid && res_ready;

    assign tcam_addr     = tcam_addr_q;
    assign tcam_wr_en    = tcam_wr_en_q;
    assign tcam_wr_index = tcam_wr_index_q;
    assign busy          = (state_q != IDLE);

    // Sequencer: issue one operation, hold the TCAM port, then return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            tcam_addr_q     <= '0;
            tcam_wr_en_q    <= 1'b0;
            tcam_wr_index_q <= '0;
            tag_q           <= '0;
            wait_cnt_q      <= '0;
            upd_prio_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd_fire) begin
                        tcam_addr_q     <= {upd_if_idx, upd_mask, upd_prefix};
                        tcam_wr_index_q <= upd_index;
                        tcam_wr_en_q    <= 1'b1;
                        upd_prio_q      <= 1'b0;
                        state_q         <= WRITE;
                    end else if (lk_fire) begin
                        tcam_addr_q  <= {4'h0, 32'h0, lk_dst};
                        tcam_wr_en_q <= 1'b0;
                        tag_q        <= lk_tag;
                        wait_cnt_q   <= LAT_W'(LOOKUP_LAT);
                        upd_prio_q   <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WRITE: begin
                    // TCAM takes the entry on this edge; wr_en is a one-cycle pulse
                    tcam_wr_en_q <= 1'b0;
                    state_q      <= IDLE;
                end
                WAIT: begin
                    wait_cnt_q <= wait_cnt_q - LAT_W'(1);
                    if (wait_cnt_q == LAT_W'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result FIFO occupancy: push and pop together leave the count unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    // Result FIFO pointers and count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    // Result FIFO storage: capture the registered TCAM result with its tag
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {tcam_addr_out, tcam_if_idx, tcam_prefix_size, tag_q};
    end

    assign head         = mem_q[rd_ptr_q];
    assign res_valid    = (cnt_q != '0);
    assign res_next_hop = head.next_hop;
    assign res_if_idx   = head.if_idx;
    assign res_prefix   = head.prefix;
    assign res_tag      = head.tag;

`ifdef LOOKUP_STATS_EN
    logic [31:0] stat_lk_q, stat_up_q;

    // Free-running activity counters, wrap at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lk_q <= '0;
            stat_up_q <= '0;
        end else begin
            if (push)     stat_lk_q <= stat_lk_q + 32'd1;
            if (upd_fire) stat_up_q <= stat_up_q + 32'd1;
        end
    end

    assign stat_lookups = stat_lk_q;
    assign stat_updates = stat_up_q;
`endif

endmodule
